bip_report_sequencer: RTL and testbench

Sequences the shared UART transmitter after the BIP processor halts: detects the rising edge of the processor's program-done flag, snapshots program counter and accumulator, and sends them as a fixed multi-byte report frame, one byte per UART transmission, paced by the transmitter's done pulse. It sits between `bip` and `uart_toplevel` in the top level and replaces the single-byte PC send with a complete, framed result report.

---
 rtl/bip_report_sequencer_if.sv | 46 ++++
 rtl/bip_report_sequencer.sv | 144 ++++++++++++++
 tb/tb_bip_report_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bip_report_sequencer_if.sv
// -----------------------------------------------------------------------------
// bip_report_sequencer_if
//   Bundles the BIP status inputs and the UART transmit handshake seen by
//   bip_report_sequencer. Signal names are written from the sequencer's point
//   of view (i_* flow into it, o_* flow out of it).
//
//   Signals:
//     i_program_done     BIP halted flag (level)
//     i_program_counter  BIP program counter, NB_ADDR bits
//     i_accumulator      BIP accumulator, NB_INSTRUCTION bits
//     i_tx_done          one-cycle pulse from the UART when a byte has finished
//     o_tx_start         one-cycle pulse requesting transmission of o_tx_data
//     o_tx_data          byte to transmit, NB_DATA bits
//     o_busy             high while a report frame is in progress
//     o_frame_done       one-cycle pulse after the last byte has finished
//
//   Modports:
//     master  the BIP/UART side (drives i_*, observes o_*)
//     slave   the sequencer itself
// -----------------------------------------------------------------------------
interface bip_report_sequencer_if #(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDR        = 11,
  parameter int NB_DATA        = 8
);

  logic                      i_program_done;
  logic [NB_ADDR-1:0]        i_program_counter;
  logic [NB_INSTRUCTION-1:0] i_accumulator;
  logic                      i_tx_done;
  logic                      o_tx_start;
  logic [NB_DATA-1:0]        o_tx_data;
  logic                      o_busy;
  logic                      o_frame_done;

  modport master (
    output i_program_done, i_program_counter, i_accumulator, i_tx_done,
    input  o_tx_start, o_tx_data, o_busy, o_frame_done
  );

  modport slave (
    input  i_program_done, i_program_counter, i_accumulator, i_tx_done,
    output o_tx_start, o_tx_data, o_busy, o_frame_done
  );

endinterface

// File: rtl/bip_report_sequencer.sv
// -----------------------------------------------------------------------------
// bip_report_sequencer
//   Sits between the BIP processor and the shared UART transmitter. On the
//   rising edge of the processor's program-done flag it snapshots the program
//   counter and accumulator and sends a fixed report frame, one byte per UART
//   transmission, paced by the transmitter's done pulse:
//     HEADER, PC[7:0], PC[15:8], ACC[7:0], ACC[15:8] [, checksum]
//   PC and ACC are zero-extended to 16 bits.
//
//   Configuration macro:
//     BIP_REPORT_CHECKSUM_EN  when defined, a sixth byte carrying the XOR of
//                             bytes 0..4 closes the frame; when undefined the
//                             frame is five bytes and no checksum register
//                             exists.
//
//   Ports:
//     i_clock  single system clock, rising edge
//     i_reset  synchronous, active-high reset
//     bus      bip_report_sequencer_if.slave (BIP status + UART handshake)
// -----------------------------------------------------------------------------
module bip_report_sequencer #(
  parameter int                 NB_INSTRUCTION = 16,
  parameter int                 NB_ADDR        = 11,
  parameter int                 NB_DATA        = 8,
  parameter logic [NB_DATA-1:0] HEADER         = 8'hA5
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  bip_report_sequencer_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

`ifdef BIP_REPORT_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  logic [1:0]                state;
  logic                      done_q;
  logic [2:0]                byte_idx;
  logic [15:0]               pc_q;
  logic [15:0]               acc_q;
`ifdef BIP_REPORT_CHECKSUM_EN
  logic [NB_DATA-1:0]        checksum_q;
`endif

  logic [NB_ADDR-1:0]        pc_in;
  logic [NB_INSTRUCTION-1:0] acc_in;
  logic                      trigger;
  logic [NB_DATA-1:0]        frame_byte;

  assign pc_in   = bus.i_program_counter;
  assign acc_in  = bus.i_accumulator;

  // A flag already high in the first cycle after reset counts as an edge,
  // because done_q is cleared by reset.
  assign trigger = bus.i_program_done & ~done_q;

  // Byte selected by the current index, taken from the snapshot registers.
  always_comb begin
    // NOTE: default assignment first so every path drives frame_byte; without
    // it a missing case arm would infer a latch.
    frame_byte = '0;
    case (byte_idx)
      3'd0:    frame_byte = HEADER;
      3'd1:    frame_byte = pc_q[7:0];
      3'd2:    frame_byte = pc_q[15:8];
      3'd3:    frame_byte = acc_q[7:0];
      3'd4:    frame_byte = acc_q[15:8];
`ifdef BIP_REPORT_CHECKSUM_EN
      3'd5:    frame_byte = checksum_q;
`endif
      default: frame_byte = '0;
    endcase
  end

  // NOTE: reset is synchronous (sampled only on the clock edge) and all state
  // uses non-blocking assignments so every register updates from pre-edge
  // values, independent of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      done_q     <= 1'b0;
      byte_idx   <= 3'd0;
      pc_q       <= '0;
      acc_q      <= '0;
`ifdef BIP_REPORT_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      done_q <= bus.i_program_done;
      case (state)
        ST_IDLE: begin
          // Edges outside IDLE are simply dropped; nothing is queued.
          if (trigger) begin
            state      <= ST_LOAD;
            byte_idx   <= 3'd0;
            pc_q       <= 16'(pc_in);
            acc_q      <= 16'(acc_in);
`ifdef BIP_REPORT_CHECKSUM_EN
            checksum_q <= '0;
`endif
          end
        end
        ST_LOAD: begin
          state <= ST_WAIT;
`ifdef BIP_REPORT_CHECKSUM_EN
          // Fold each payload byte in as it is loaded; the checksum byte
          // itself is not folded.
          if (byte_idx != LAST_IDX) begin
            checksum_q <= checksum_q ^ frame_byte;
          end
`endif
        end
        ST_WAIT: begin
          if (bus.i_tx_done) begin
            if (byte_idx == LAST_IDX) begin
              state <= ST_DONE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= ST_LOAD;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state, so a reset clears them one cycle
  // later. o_tx_data holds the selected byte through LOAD and WAIT, i.e. from
  // the start pulse until the matching done pulse.
  assign bus.o_tx_start   = (state == ST_LOAD);
  assign bus.o_busy       = (state == ST_LOAD) || (state == ST_WAIT);
  assign bus.o_frame_done = (state == ST_DONE);
  assign bus.o_tx_data    = bus.o_busy ? frame_byte : '0;

endmodule

// File: tb/tb_bip_report_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bip_report_sequencer
//   Self-checking bench for bip_report_sequencer. Expected frame bytes are
//   pushed to a scoreboard queue when a frame is triggered and popped as the
//   DUT issues each start pulse; the bench plays the UART, answering every
//   start with a done pulse GAP cycles later. Build with
//   +define+BIP_REPORT_CHECKSUM_EN to exercise the checksum variant.
// -----------------------------------------------------------------------------
module tb_bip_report_sequencer;

  localparam int NB_INSTRUCTION = 16;
  localparam int NB_ADDR        = 11;
  localparam int NB_DATA        = 8;
  localparam int GAP            = 20;
  localparam int START_TIMEOUT  = 50;

`ifdef BIP_REPORT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic i_clock = 1'b0;
  logic i_reset;

  always #5 i_clock = ~i_clock;

  bip_report_sequencer_if #(
    .NB_INSTRUCTION (NB_INSTRUCTION),
    .NB_ADDR        (NB_ADDR),
    .NB_DATA        (NB_DATA)
  ) bus ();

  bip_report_sequencer #(
    .NB_INSTRUCTION (NB_INSTRUCTION),
    .NB_ADDR        (NB_ADDR),
    .NB_DATA        (NB_DATA),
    .HEADER         (8'hA5)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  // One cycle: outputs are observed 1 time unit after the edge, and inputs
  // driven here are sampled by the following edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Reference frame builder: header, zero-extended PC and ACC, optional XOR.
  task automatic push_frame(input logic [15:0] pc, input logic [15:0] acc);
    logic [7:0] x;
    exp_q.push_back(8'hA5);
    exp_q.push_back(pc[7:0]);
    exp_q.push_back(pc[15:8]);
    exp_q.push_back(acc[7:0]);
    exp_q.push_back(acc[15:8]);
    x = 8'hA5 ^ pc[7:0] ^ pc[15:8] ^ acc[7:0] ^ acc[15:8];
    if (CSUM) exp_q.push_back(x);
  endtask

  // Raise the done flag (a low level must precede it) and expect byte 0 to
  // start on the very next cycle.
  task automatic trigger(input string name);
    bus.i_program_done = 1'b1;
    tick();
    checks++;
    if (bus.o_tx_start !== 1'b1 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s trigger latency: start=%b busy=%b, required start=1 busy=1 one cycle after edge",
               name, bus.o_tx_start, bus.o_busy);
    end
  endtask

  // Plays the UART for the queued frame. abort_at >= 0 returns a few cycles
  // into the WAIT of that byte without sending its done pulse.
  task automatic run_frame(input string name, input bit mutate, input int abort_at);
    int         n;
    int         w;
    bit         bad;
    logic [7:0] exp;
    n = exp_q.size();
    for (int b = 0; b < n; b++) begin
      w = 0;
      while (bus.o_tx_start !== 1'b1 && w < START_TIMEOUT) begin
        tick();
        w++;
      end
      checks++;
      if (bus.o_tx_start !== 1'b1) begin
        errors++;
        $display("FAIL %s start timeout: byte %0d, no start within %0d cycles", name, b, START_TIMEOUT);
        exp_q.delete();
        return;
      end
      exp = exp_q.pop_front();
      checks++;
      if (bus.o_tx_data !== exp || bus.o_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s byte %0d: data=%h busy=%b, required data=%h busy=1",
                 name, b, bus.o_tx_data, bus.o_busy, exp);
      end
      if (b == abort_at) begin
        tick();
        tick();
        tick();
        return;
      end
      bad = 1'b0;
      for (int g = 0; g < GAP; g++) begin
        tick();
        if (mutate && b == 1 && g == 2) bus.i_program_done = 1'b0;
        if (mutate && b == 1 && g == 4) begin
          bus.i_program_done = 1'b1;
          bus.i_accumulator  = 16'h0000;
        end
        if (bus.o_tx_start !== 1'b0 || bus.o_tx_data !== exp ||
            bus.o_busy !== 1'b1 || bus.o_frame_done !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s hold byte %0d: start/data/busy/frame_done changed while waiting, required 0/%h/1/0",
                 name, b, exp);
      end
      bus.i_tx_done = 1'b1;
      tick();
      bus.i_tx_done = 1'b0;
      if (b < n - 1) begin
        checks++;
        if (bus.o_tx_start !== 1'b1) begin
          errors++;
          $display("FAIL %s next-start latency byte %0d: start=%b, required 1 one cycle after done",
                   name, b + 1, bus.o_tx_start);
        end
      end else begin
        checks++;
        if (bus.o_frame_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0) begin
          errors++;
          $display("FAIL %s frame end: frame_done=%b busy=%b start=%b, required 1/0/0",
                   name, bus.o_frame_done, bus.o_busy, bus.o_tx_start);
        end
        tick();
        checks++;
        if (bus.o_frame_done !== 1'b0 || bus.o_busy !== 1'b0) begin
          errors++;
          $display("FAIL %s frame_done width: frame_done=%b busy=%b, required 0/0",
                   name, bus.o_frame_done, bus.o_busy);
        end
      end
    end
  endtask

  // No output activity at all for the given number of cycles.
  task automatic expect_quiet(input string name, input int cycles);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b0 ||
          bus.o_frame_done !== 1'b0 || bus.o_tx_data !== 8'h00) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s quiet: output activity seen, required start/busy/frame_done/data all 0", name);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (bus.o_tx_start !== 1'b0 || bus.o_tx_data !== 8'h00 ||
        bus.o_busy !== 1'b0 || bus.o_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs: start=%b data=%h busy=%b frame_done=%b, required all 0",
               name, bus.o_tx_start, bus.o_tx_data, bus.o_busy, bus.o_frame_done);
    end
  endtask

  task automatic test_reset();
    i_reset               = 1'b1;
    bus.i_program_done    = 1'b0;
    bus.i_program_counter = '0;
    bus.i_accumulator     = '0;
    bus.i_tx_done         = 1'b0;
    tick();
    tick();
    tick();
    check_outputs_zero("reset");
    i_reset = 1'b0;
    expect_quiet("post_reset", 5);
  endtask

  task automatic test_idle_tx_done();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    expect_quiet("idle_tx_done", 10);
  endtask

  task automatic test_basic_frame();
    bus.i_program_counter = 11'h123;
    bus.i_accumulator     = 16'hBEEF;
    exp_q = '{8'hA5, 8'h23, 8'h01, 8'hEF, 8'hBE};
    if (CSUM) exp_q.push_back(8'hD6);
    trigger("basic");
    run_frame("basic", 1'b0, -1);
    bus.i_program_done = 1'b0;
    expect_quiet("basic_after", 5);
  endtask

  task automatic test_snapshot_retrigger();
    bus.i_program_counter = 11'h123;
    bus.i_accumulator     = 16'hBEEF;
    exp_q = '{8'hA5, 8'h23, 8'h01, 8'hEF, 8'hBE};
    if (CSUM) exp_q.push_back(8'hD6);
    trigger("snapshot");
    run_frame("snapshot", 1'b1, -1);
    // Flag stays high: the mid-frame re-rise must not have queued a frame.
    expect_quiet("snapshot_no_second", 30);
    bus.i_program_done    = 1'b0;
    tick();
    bus.i_program_counter = 11'h055;
    bus.i_accumulator     = 16'h1234;
    push_frame(16'h0055, 16'h1234);
    trigger("retrigger");
    run_frame("retrigger", 1'b0, -1);
    bus.i_program_done = 1'b0;
    tick();
  endtask

  // A rise on the first IDLE cycle after frame_done is accepted.
  task automatic test_back_to_back();
    bus.i_program_counter = 11'h3C4;
    bus.i_accumulator     = 16'h5A0F;
    push_frame(16'h03C4, 16'h5A0F);
    trigger("b2b_first");
    bus.i_program_done = 1'b0;
    run_frame("b2b_first", 1'b0, -1);
    bus.i_program_counter = 11'h001;
    bus.i_accumulator     = 16'hFFFF;
    push_frame(16'h0001, 16'hFFFF);
    trigger("b2b_second");
    run_frame("b2b_second", 1'b0, -1);
    bus.i_program_done = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    bus.i_program_counter = 11'h123;
    bus.i_accumulator     = 16'hBEEF;
    push_frame(16'h0123, 16'hBEEF);
    trigger("mid_reset");
    run_frame("mid_reset", 1'b0, 2);
    i_reset            = 1'b1;
    bus.i_program_done = 1'b0;
    tick();
    check_outputs_zero("mid_reset_asserted");
    i_reset = 1'b0;
    exp_q.delete();
    expect_quiet("mid_reset_no_resume", 40);
    bus.i_accumulator = 16'h0F0F;
    push_frame(16'h0123, 16'h0F0F);
    trigger("mid_reset_new");
    run_frame("mid_reset_new", 1'b0, -1);
    bus.i_program_done = 1'b0;
    tick();
  endtask

  task automatic test_width_extension();
    bus.i_program_counter = 11'h7FF;
    bus.i_accumulator     = 16'h8001;
    exp_q = '{8'hA5, 8'hFF, 8'h07, 8'h01, 8'h80};
    if (CSUM) exp_q.push_back(8'hDC);
    trigger("width");
    run_frame("width", 1'b0, -1);
    bus.i_program_done = 1'b0;
    tick();
  endtask

  // Flag held high through reset counts as an edge on the first cycle after.
  task automatic test_flag_high_after_reset();
    bus.i_program_counter = 11'h2AA;
    bus.i_accumulator     = 16'h1357;
    i_reset               = 1'b1;
    bus.i_program_done    = 1'b1;
    tick();
    check_outputs_zero("flag_reset_held");
    i_reset = 1'b0;
    push_frame(16'h02AA, 16'h1357);
    tick();
    checks++;
    if (bus.o_tx_start !== 1'b1) begin
      errors++;
      $display("FAIL flag_after_reset start: start=%b, required 1", bus.o_tx_start);
    end
    run_frame("flag_after_reset", 1'b0, -1);
    bus.i_program_done = 1'b0;
    expect_quiet("flag_after_reset_end", 5);
  endtask

  initial begin
    test_reset();
    test_idle_tx_done();
    test_basic_frame();
    test_snapshot_retrigger();
    test_back_to_back();
    test_reset_mid_frame();
    test_width_extension();
    test_flag_high_after_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
